sync_fifo_param: RTL

Parametrised single-clock FIFO; successor to the fixed 8-bit × 16-entry FIFO. Generalises data width and depth and adds occupancy count, programmable almost-full/almost-empty flags, clearable sticky error flags and an optional registered read port. Sits between any producer and consumer in the same clock domain.

---
 rtl/sync_fifo_param.sv | 113 +++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty flags and sticky error flags.
// Define SYNC_FIFO_OUTREG_EN for a registered read port; the default build is first-word fall-through.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] C_AF  = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] C_AE  = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] C_ONE = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   r_rptr;
    logic              r_overflow;
    logic              r_underflow;

    logic [ADDR_W:0]   w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_we;
    logic              w_re;

    // The extra pointer MSB distinguishes a full ring from an empty one.
    assign w_count = r_wptr - r_rptr;
    assign w_full  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                     (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
    assign w_empty = (r_wptr == r_rptr);
    assign w_we    = wr_en & ~w_full;
    assign w_re    = rd_en & ~w_empty;

    always_ff @(posedge clk) begin
        if (rst_n && w_we) begin
            r_mem[r_wptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_we) begin
                r_wptr <= r_wptr + C_ONE;
            end
            if (w_re) begin
                r_rptr <= r_rptr + C_ONE;
            end
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (wr_en & w_full)  | (r_overflow  & ~clr_err);
            r_underflow <= (rd_en & w_empty) | (r_underflow & ~clr_err);
        end
    end

`ifdef SYNC_FIFO_OUTREG_EN
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_re) begin
            r_rd_data  <= r_mem[r_rptr[ADDR_W-1:0]];
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
`else
    assign rd_data  = r_mem[r_rptr[ADDR_W-1:0]];
    assign rd_valid = ~w_empty;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = w_count;
    assign almost_full  = (w_count >= C_AF);
    assign almost_empty = (w_count <= C_AE);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
